// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: per-slave AHB arbiter with round-robin address-phase grant and data-phase tracking
//
// Ports:
//   HCLOCK       clock, all state updates on the rising edge
//   HRESET       synchronous active-high reset
//   REQ          per-master request (HTRANS != IDLE and address decodes here)
//   LOCK         per-master HLOCK
//   TRANS_G      HTRANS of the currently granted master
//   BURST_G      HBURST of the currently granted master
//   READY        HREADY from this slave; nothing changes while low
//   GRANT        one-hot address-phase grant, zero when nobody owns the bus
//   GRANT_IDX    index of the address-phase owner
//   GRANT_VALID  an address-phase owner exists
//   DATA_IDX     index of the data-phase owner
//   DATA_VALID   a data phase is in progress
//   LOCKED       the owner holds a locked sequence
//
// Build option: define AHB_ARB_FIXED_PRIORITY_EN to make the lowest requesting
// index win every arbitration instead of rotating from the last winner.
module ahb_rr_arbiter #(
  parameter int MASTERS  = 3,
  parameter int IDX_W    = 4,
  parameter int HOLD_MAX = 16
) (
  input  logic               HCLOCK,
  input  logic               HRESET,
  input  logic [MASTERS-1:0] REQ,
  input  logic [MASTERS-1:0] LOCK,
  input  logic [1:0]         TRANS_G,
  input  logic [2:0]         BURST_G,
  input  logic               READY,
  output logic [MASTERS-1:0] GRANT,
  output logic [IDX_W-1:0]   GRANT_IDX,
  output logic               GRANT_VALID,
  output logic [IDX_W-1:0]   DATA_IDX,
  output logic               DATA_VALID,
  output logic               LOCKED
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  typedef enum logic [1:0] {IDLE, OWNED, LOCKED_OWN} state_e;
  state_e state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d, pick;
  logic [IDX_W-1:0] gidx_q, gidx_d, didx_q, didx_d, ptr_q, ptr_d, win_idx;
  logic dvalid_q, dvalid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic beat, own_lock, own_req, others, forced, hold;
  assign beat     = TRANS_G == 2'b10 || TRANS_G == 2'b11;
  assign own_lock = |(LOCK & grant_q);
  assign own_req  = |(REQ & grant_q);
  assign others   = |(REQ & ~grant_q);
  assign forced   = BURST_G == 3'b001 && int'(cnt_q) >= HOLD_MAX && !own_lock && others;
  // TRANS_G[0] is set for both SEQ and BUSY, the two burst-continuation codes
  assign hold = state_q == LOCKED_OWN ? (own_lock || TRANS_G != 2'b00)
                                      : state_q != IDLE && (own_lock || (own_req && TRANS_G[0] && !forced));
`ifdef AHB_ARB_FIXED_PRIORITY_EN
  assign pick = REQ;
`else
  logic [MASTERS-1:0] hi;
  // requesters above the last winner take precedence; wrap to the full set otherwise
  always_comb begin
    hi = '0;
    for (int i = 0; i < MASTERS; i++) hi[i] = REQ[i] && (IDX_W'(i) > ptr_q);
  end
  assign pick = (|hi) ? hi : REQ;
`endif
  always_comb begin
    win_idx = '0;
    for (int i = MASTERS - 1; i >= 0; i--) if (pick[i]) win_idx = IDX_W'(i);
  end
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    didx_d   = didx_q;
    dvalid_d = dvalid_q;
    cnt_d    = cnt_q;
    if (READY) begin
      dvalid_d = state_q != IDLE && beat;
      didx_d   = dvalid_d ? gidx_q : didx_q;
      if (hold) begin
        state_d = (state_q == LOCKED_OWN || own_lock) ? LOCKED_OWN : OWNED;
      end else if (|REQ) begin
        state_d = OWNED;
        grant_d = MASTERS'(1) << win_idx;
        gidx_d  = win_idx;
        ptr_d   = win_idx;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
      // a NONSEQ restarts the count and is itself the first beat
      cnt_d = grant_d != grant_q ? '0
            : TRANS_G == 2'b10 ? CW'(1)
            : (TRANS_G == 2'b11 && int'(cnt_q) < HOLD_MAX) ? cnt_q + CW'(1) : cnt_q;
    end
  end
  always_ff @(posedge HCLOCK) begin
    if (HRESET) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= IDX_W'(MASTERS - 1);
      didx_q   <= '0;
      dvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      didx_q   <= didx_d;
      dvalid_q <= dvalid_d;
      cnt_q    <= cnt_d;
    end
  end
  assign GRANT       = grant_q;
  assign GRANT_IDX   = gidx_q;
  assign GRANT_VALID = state_q != IDLE;
  assign DATA_IDX    = didx_q;
  assign DATA_VALID  = dvalid_q;
  assign LOCKED      = state_q == LOCKED_OWN;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed and random checks of ahb_rr_arbiter against a behavioural model
module tb_ahb_rr_arbiter;
  localparam int M = 3;
  localparam int IW = 4;
  localparam int HM = 4;
  localparam logic [1:0] IDL = 2'b00, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, INC = 3'b001, INC4 = 3'b011;
  logic HCLOCK = 1'b0, HRESET = 1'b1, READY = 1'b0;
  logic [M-1:0] REQ = '0, LOCK = '0;
  logic [1:0] TRANS_G = '0;
  logic [2:0] BURST_G = '0;
  logic [M-1:0] GRANT;
  logic [IW-1:0] GRANT_IDX, DATA_IDX;
  logic GRANT_VALID, DATA_VALID, LOCKED;
  int n_cmp = 0, n_err = 0;
  int m_owner = -1, m_ptr = M - 1, m_cnt = 0, m_gidx = 0, m_didx = 0;
  bit m_lk = 0, m_dv = 0;
  ahb_rr_arbiter #(.MASTERS(M), .IDX_W(IW), .HOLD_MAX(HM)) dut (
    .HCLOCK(HCLOCK), .HRESET(HRESET), .REQ(REQ), .LOCK(LOCK), .TRANS_G(TRANS_G),
    .BURST_G(BURST_G), .READY(READY), .GRANT(GRANT), .GRANT_IDX(GRANT_IDX),
    .GRANT_VALID(GRANT_VALID), .DATA_IDX(DATA_IDX), .DATA_VALID(DATA_VALID), .LOCKED(LOCKED)
  );
  always #5 HCLOCK = ~HCLOCK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit bt(input logic [31:0] v, input int i);
    return |((v >> i) & 32'd1);
  endfunction
  function automatic logic [13:0] dut_vec();
    return {GRANT, GRANT_IDX, GRANT_VALID, DATA_IDX, DATA_VALID, LOCKED};
  endfunction
  function automatic logic [13:0] mdl_vec();
    logic [M-1:0] g;
    g = m_owner >= 0 ? M'(1 << m_owner) : '0;
    return {g, IW'(m_gidx), m_owner >= 0, IW'(m_didx), m_dv, m_lk};
  endfunction
  task automatic model_step();
    int nw, c;
    bit keep, olock, oreq, oth, forced;
    if (HRESET) begin
      m_owner = -1; m_lk = 0; m_ptr = M - 1; m_cnt = 0; m_gidx = 0; m_didx = 0; m_dv = 0;
      return;
    end
    if (!READY) return;
    m_dv = m_owner >= 0 && (TRANS_G == NSQ || TRANS_G == SQ);
    if (m_dv) m_didx = m_gidx;
    olock = m_owner >= 0 && bt(32'(LOCK), m_owner);
    oreq  = m_owner >= 0 && bt(32'(REQ), m_owner);
    oth = 0;
    for (int k = 0; k < M; k++) if (k != m_owner && bt(32'(REQ), k)) oth = 1;
    forced = BURST_G == INC && m_cnt >= HM && !olock && oth;
    keep = m_lk ? (olock || TRANS_G != IDL)
                : (m_owner >= 0 && (olock || (oreq && (TRANS_G == SQ || TRANS_G == 2'b01) && !forced)));
    if (keep) begin
      nw = m_owner;
      m_lk = m_lk || olock;
    end else begin
      m_lk = 0;
      nw = -1;
      for (int k = 1; k <= M; k++) begin
        c = (m_ptr + k) % M;
        if (nw < 0 && bt(32'(REQ), c)) nw = c;
      end
      if (nw >= 0) begin m_ptr = nw; m_gidx = nw; end
    end
    if (nw != m_owner) m_cnt = 0;
    else if (TRANS_G == NSQ) m_cnt = 1;
    else if (TRANS_G == SQ && m_cnt < HM) m_cnt++;
    m_owner = nw;
  endtask
  task automatic cyc(input logic rst, input logic [M-1:0] req, input logic [M-1:0] lock,
                     input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
    HRESET = rst; REQ = req; LOCK = lock; TRANS_G = tr; BURST_G = bu; READY = rdy;
    @(posedge HCLOCK);
    model_step();
    #1;
    chk("outs", 32'(dut_vec()), 32'(mdl_vec()));
  endtask
  initial begin
    cyc(1'b1, 3'b000, 3'b000, IDL, SGL, 1'b1);
    chk("reset", 32'(dut_vec()), 32'd0);
    cyc(1'b0, 3'b111, 3'b000, NSQ, SGL, 1'b1); chk("rr0", 32'(GRANT), 32'd1);
    cyc(1'b0, 3'b111, 3'b000, NSQ, SGL, 1'b1); chk("rr1", 32'(GRANT), 32'd2);
    cyc(1'b0, 3'b111, 3'b000, NSQ, SGL, 1'b1); chk("rr2", 32'(GRANT), 32'd4);
    cyc(1'b0, 3'b111, 3'b000, NSQ, SGL, 1'b1); chk("rr3", 32'(GRANT), 32'd1);
    cyc(1'b1, 3'b000, 3'b000, IDL, SGL, 1'b1);
    cyc(1'b0, 3'b001, 3'b000, IDL, SGL, 1'b1);
    cyc(1'b0, 3'b001, 3'b000, NSQ, INC4, 1'b1); chk("inc4_b1", 32'(GRANT), 32'd1);
    cyc(1'b0, 3'b011, 3'b000, SQ, INC4, 1'b1);  chk("inc4_b2", 32'(GRANT), 32'd1);
    cyc(1'b0, 3'b011, 3'b000, SQ, INC4, 1'b1);  chk("inc4_b3", 32'(GRANT), 32'd1);
    cyc(1'b0, 3'b011, 3'b000, SQ, INC4, 1'b1);  chk("inc4_b4", 32'(GRANT), 32'd1);
    cyc(1'b0, 3'b010, 3'b000, IDL, SGL, 1'b1);  chk("inc4_next", 32'(GRANT), 32'd2);
    cyc(1'b0, 3'b010, 3'b000, NSQ, INC4, 1'b1);
    cyc(1'b0, 3'b011, 3'b000, SQ, INC4, 1'b1);
    cyc(1'b0, 3'b101, 3'b000, SQ, INC4, 1'b0);
    chk("stall0", 32'({GRANT, GRANT_IDX, DATA_IDX, DATA_VALID}), 32'({3'b010, 4'd1, 4'd1, 1'b1}));
    cyc(1'b0, 3'b100, 3'b001, SQ, INC4, 1'b0);
    chk("stall1", 32'({GRANT, GRANT_IDX, DATA_IDX, DATA_VALID}), 32'({3'b010, 4'd1, 4'd1, 1'b1}));
    cyc(1'b0, 3'b111, 3'b010, IDL, INC, 1'b0);
    chk("stall2", 32'({GRANT, GRANT_IDX, DATA_IDX, DATA_VALID}), 32'({3'b010, 4'd1, 4'd1, 1'b1}));
    cyc(1'b1, 3'b000, 3'b000, IDL, SGL, 1'b1);
    cyc(1'b0, 3'b100, 3'b000, IDL, SGL, 1'b1);
    cyc(1'b0, 3'b100, 3'b000, NSQ, INC, 1'b1);
    cyc(1'b0, 3'b101, 3'b000, SQ, INC, 1'b1);
    cyc(1'b0, 3'b101, 3'b000, SQ, INC, 1'b1);
    cyc(1'b0, 3'b101, 3'b000, SQ, INC, 1'b1);  chk("hm_hold", 32'(GRANT), 32'd4);
    cyc(1'b0, 3'b101, 3'b000, SQ, INC, 1'b1);
    chk("hm_rel", 32'({GRANT, DATA_IDX}), 32'({3'b001, 4'd2}));
    cyc(1'b0, 3'b101, 3'b000, NSQ, INC, 1'b1); chk("hm_data", 32'(DATA_IDX), 32'd0);
    cyc(1'b1, 3'b000, 3'b000, IDL, SGL, 1'b1);
    cyc(1'b0, 3'b010, 3'b010, IDL, SGL, 1'b1);
    cyc(1'b0, 3'b011, 3'b010, NSQ, INC, 1'b1); chk("lk_in", 32'({LOCKED, GRANT}), 32'({1'b1, 3'b010}));
    cyc(1'b0, 3'b001, 3'b010, IDL, SGL, 1'b1); chk("lk_drop0", 32'({LOCKED, GRANT}), 32'({1'b1, 3'b010}));
    cyc(1'b0, 3'b001, 3'b010, IDL, SGL, 1'b1); chk("lk_drop1", 32'({LOCKED, GRANT}), 32'({1'b1, 3'b010}));
    cyc(1'b0, 3'b011, 3'b000, NSQ, INC, 1'b1); chk("lk_busy", 32'({LOCKED, GRANT}), 32'({1'b1, 3'b010}));
    cyc(1'b0, 3'b001, 3'b000, IDL, SGL, 1'b1); chk("lk_rel", 32'({LOCKED, GRANT}), 32'({1'b0, 3'b001}));
    cyc(1'b0, 3'b011, 3'b001, SQ, INC, 1'b1);  chk("lk2_in", 32'(LOCKED), 32'd1);
    cyc(1'b1, 3'b110, 3'b001, SQ, INC, 1'b1);  chk("rst_mid", 32'(dut_vec()), 32'd0);
    cyc(1'b0, 3'b110, 3'b000, IDL, SGL, 1'b1); chk("rst_first", 32'(GRANT), 32'd2);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 99) == 0,
          M'($urandom),
          $urandom_range(0, 7) == 0 ? M'($urandom) : M'(0),
          $urandom_range(0, 2) == 0 ? 2'($urandom) : SQ,
          $urandom_range(0, 1) == 0 ? INC : 3'($urandom),
          $urandom_range(0, 3) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
